// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and compare helpers for the MIPS hazard scoreboard.
// T_use / T_new encodings and forwarding select codes.
package hazard_scoreboard_pkg;

    localparam int RAW = 5;
    localparam int TW  = 2;

    localparam logic [TW-1:0] TUSE_D    = 2'd0;
    localparam logic [TW-1:0] TUSE_E    = 2'd1;
    localparam logic [TW-1:0] TUSE_M    = 2'd2;
    localparam logic [TW-1:0] TUSE_NONE = 2'd3;

    localparam logic [TW-1:0] TNEW_PC8  = 2'd0;
    localparam logic [TW-1:0] TNEW_ALU  = 2'd1;
    localparam logic [TW-1:0] TNEW_LOAD = 2'd2;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    // A stage can supply operand a only once its result is actually ready.
    function automatic logic fwd_hit(input logic [RAW-1:0] a,
                                     input logic [RAW-1:0] s_addr,
                                     input logic [TW-1:0]  s_tnew);
        return (a != '0) && (s_addr == a) && (s_tnew == '0);
    endfunction

    function automatic logic late_hit(input logic [RAW-1:0] a,
                                      input logic [TW-1:0]  tuse,
                                      input logic [RAW-1:0] s_addr,
                                      input logic [TW-1:0]  s_tnew);
        return (s_addr == a) && (s_tnew > tuse);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_stage.sv
// One pipeline stage of writer shadow state (destination + remaining T_new).
// Optional saturating decrement on the way in; bubble loads an empty record.
module hz_stage_reg
    import hazard_scoreboard_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           i_bubble,
    input  logic           i_dec,
    input  logic [RAW-1:0] i_addr,
    input  logic [TW-1:0]  i_tnew,
    output logic [RAW-1:0] o_addr,
    output logic [TW-1:0]  o_tnew
);

    logic [RAW-1:0] r_addr;
    logic [TW-1:0]  r_tnew;
    logic [TW-1:0]  w_tnew_nxt;

    always_comb begin
        w_tnew_nxt = i_tnew;
        if (i_dec && (i_tnew != '0))
            w_tnew_nxt = i_tnew - TW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_tnew <= '0;
        end else if (i_bubble) begin
            r_addr <= '0;
            r_tnew <= '0;
        end else begin
            r_addr <= i_addr;
            r_tnew <= w_tnew_nxt;
        end
    end

    assign o_addr = r_addr;
    assign o_tnew = r_tnew;

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall and forwarding-select generation for a five-stage MIPS pipeline.
// Optional STALL_COUNT_EN adds a free-running stall cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [RAW-1:0] D_rs,
    input  logic [RAW-1:0] D_rt,
    input  logic [TW-1:0]  D_tuse_rs,
    input  logic [TW-1:0]  D_tuse_rt,
    input  logic           D_wr_en,
    input  logic [RAW-1:0] D_wr_addr,
    input  logic [TW-1:0]  D_tnew,
    output logic           stall,
    output logic [1:0]     fwd_D_rs,
    output logic [1:0]     fwd_D_rt,
    output logic [1:0]     fwd_E_rs,
    output logic [1:0]     fwd_E_rt,
`ifdef STALL_COUNT_EN
    output logic [1:0]     fwd_M_rt,
    output logic [31:0]    stall_cnt
`else
    output logic [1:0]     fwd_M_rt
`endif
);

    logic [RAW-1:0] w_d_addr;
    logic [RAW-1:0] w_e_addr, w_m_addr, w_w_addr;
    logic [TW-1:0]  w_e_tnew, w_m_tnew, w_w_tnew;
    logic           w_stall_rs, w_stall_rt, w_stall;
    logic [RAW-1:0] r_e_rs, r_e_rt, r_m_rt;

    // Non-writers travel as address 0, which can never match a live operand.
    assign w_d_addr = D_wr_en ? D_wr_addr : '0;

    hz_stage_reg u_stage_e (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (w_stall),
        .i_dec    (1'b0),
        .i_addr   (w_d_addr),
        .i_tnew   (D_tnew),
        .o_addr   (w_e_addr),
        .o_tnew   (w_e_tnew)
    );

    hz_stage_reg u_stage_m (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (1'b0),
        .i_dec    (1'b1),
        .i_addr   (w_e_addr),
        .i_tnew   (w_e_tnew),
        .o_addr   (w_m_addr),
        .o_tnew   (w_m_tnew)
    );

    hz_stage_reg u_stage_w (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (1'b0),
        .i_dec    (1'b1),
        .i_addr   (w_m_addr),
        .i_tnew   (w_m_tnew),
        .o_addr   (w_w_addr),
        .o_tnew   (w_w_tnew)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e_rs <= '0;
            r_e_rt <= '0;
            r_m_rt <= '0;
        end else begin
            r_e_rs <= w_stall ? '0 : D_rs;
            r_e_rt <= w_stall ? '0 : D_rt;
            r_m_rt <= r_e_rt;
        end
    end

    // W is never consulted for stalls: its T_new has always drained to 0.
    assign w_stall_rs = (D_tuse_rs != TUSE_NONE) && (D_rs != '0) &&
                        (late_hit(D_rs, D_tuse_rs, w_e_addr, w_e_tnew) ||
                         late_hit(D_rs, D_tuse_rs, w_m_addr, w_m_tnew));
    assign w_stall_rt = (D_tuse_rt != TUSE_NONE) && (D_rt != '0) &&
                        (late_hit(D_rt, D_tuse_rt, w_e_addr, w_e_tnew) ||
                         late_hit(D_rt, D_tuse_rt, w_m_addr, w_m_tnew));
    assign w_stall = w_stall_rs | w_stall_rt;
    assign stall   = w_stall;

    always_comb begin
        fwd_D_rs = FWD_RF;
        fwd_D_rt = FWD_RF;
        fwd_E_rs = FWD_RF;
        fwd_E_rt = FWD_RF;
        fwd_M_rt = FWD_RF;

        if      (fwd_hit(D_rs, w_e_addr, w_e_tnew)) fwd_D_rs = FWD_E;
        else if (fwd_hit(D_rs, w_m_addr, w_m_tnew)) fwd_D_rs = FWD_M;
        else if (fwd_hit(D_rs, w_w_addr, w_w_tnew)) fwd_D_rs = FWD_W;

        if      (fwd_hit(D_rt, w_e_addr, w_e_tnew)) fwd_D_rt = FWD_E;
        else if (fwd_hit(D_rt, w_m_addr, w_m_tnew)) fwd_D_rt = FWD_M;
        else if (fwd_hit(D_rt, w_w_addr, w_w_tnew)) fwd_D_rt = FWD_W;

        if      (fwd_hit(r_e_rs, w_m_addr, w_m_tnew)) fwd_E_rs = FWD_M;
        else if (fwd_hit(r_e_rs, w_w_addr, w_w_tnew)) fwd_E_rs = FWD_W;

        if      (fwd_hit(r_e_rt, w_m_addr, w_m_tnew)) fwd_E_rt = FWD_M;
        else if (fwd_hit(r_e_rt, w_w_addr, w_w_tnew)) fwd_E_rt = FWD_W;

        if (fwd_hit(r_m_rt, w_w_addr, w_w_tnew)) fwd_M_rt = FWD_W;
    end

`ifdef STALL_COUNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (w_stall)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench for hazard_scoreboard: a stream of D-stage instructions
// with expected stall/forward codes, plus a reset-during-stall sequence.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_wr_addr;
    logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
    logic       D_wr_en;
    logic       stall;
    logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt;
`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk       (clk),
        .reset     (reset),
        .D_rs      (D_rs),
        .D_rt      (D_rt),
        .D_tuse_rs (D_tuse_rs),
        .D_tuse_rt (D_tuse_rt),
        .D_wr_en   (D_wr_en),
        .D_wr_addr (D_wr_addr),
        .D_tnew    (D_tnew),
        .stall     (stall),
        .fwd_D_rs  (fwd_D_rs),
        .fwd_D_rt  (fwd_D_rt),
        .fwd_E_rs  (fwd_E_rs),
        .fwd_E_rt  (fwd_E_rt),
`ifdef STALL_COUNT_EN
        .fwd_M_rt  (fwd_M_rt),
        .stall_cnt (stall_cnt)
`else
        .fwd_M_rt  (fwd_M_rt)
`endif
    );

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tu_rs;
        logic [1:0] tu_rt;
        logic       we;
        logic [4:0] wa;
        logic [1:0] tn;
        logic       x_stall;
        logic [1:0] x_fd_rs;
        logic [1:0] x_fd_rt;
        logic [1:0] x_fe_rs;
        logic [1:0] x_fe_rt;
        logic [1:0] x_fm_rt;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(input int rs, input int rt, input int tur, input int tut,
                                input int we, input int wa, input int tn, input int st,
                                input int fdrs, input int fdrt, input int fers,
                                input int fert, input int fmrt);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.tu_rs = 2'(tur); v.tu_rt = 2'(tut);
        v.we = 1'(we); v.wa = 5'(wa); v.tn = 2'(tn);
        v.x_stall = 1'(st); v.x_fd_rs = 2'(fdrs); v.x_fd_rt = 2'(fdrt);
        v.x_fe_rs = 2'(fers); v.x_fe_rt = 2'(fert); v.x_fm_rt = 2'(fmrt);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        D_rs = v.rs; D_rt = v.rt; D_tuse_rs = v.tu_rs; D_tuse_rt = v.tu_rt;
        D_wr_en = v.we; D_wr_addr = v.wa; D_tnew = v.tn;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_stall"}, int'(stall), 0);
        chk({tag, "_fd_rs"}, int'(fwd_D_rs), 0);
        chk({tag, "_fd_rt"}, int'(fwd_D_rt), 0);
        chk({tag, "_fe_rs"}, int'(fwd_E_rs), 0);
        chk({tag, "_fe_rt"}, int'(fwd_E_rt), 0);
        chk({tag, "_fm_rt"}, int'(fwd_M_rt), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Codes: tuse D=0 E=1 M=2 NONE=3; fwd RF=0 E=1 M=2 W=3.
        // lw $1 ; add $2,$1,$3 (one stall, then W forward into E)
        vecs[0]  = mk( 0, 0, 1, 3, 1, 1, 2,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk( 1, 3, 1, 1, 1, 2, 1,  1, 0, 0, 0, 0, 0);
        vecs[2]  = mk( 1, 3, 1, 1, 1, 2, 1,  0, 0, 0, 0, 0, 0);
        vecs[3]  = mk( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 3, 0, 0);
        // lw $1 ; beq $1,$0 (two stalls, then W forward into D)
        vecs[4]  = mk( 0, 0, 1, 3, 1, 1, 2,  0, 0, 0, 0, 0, 0);
        vecs[5]  = mk( 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        vecs[6]  = mk( 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        vecs[7]  = mk( 1, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0, 0, 0);
        // add $5 ; beq $5,$5
        vecs[8]  = mk( 6, 7, 1, 1, 1, 5, 1,  0, 0, 0, 0, 0, 0);
        vecs[9]  = mk( 5, 5, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        vecs[10] = mk( 5, 5, 0, 0, 0, 0, 0,  0, 2, 2, 0, 0, 0);
        // jal ; jr $31 (beq $5,$5 now in E picks up $5 from W)
        vecs[11] = mk( 0, 0, 3, 3, 1, 31, 0, 0, 0, 0, 3, 3, 0);
        vecs[12] = mk(31, 0, 0, 3, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        // lw $4 ; sw $4,0($6) ; nop ; nop
        vecs[13] = mk( 0, 0, 1, 3, 1, 4, 2,  0, 0, 0, 2, 0, 0);
        vecs[14] = mk( 6, 4, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[15] = mk( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[16] = mk( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 3);
        // writers to $0 ahead of beq $0,$0
        vecs[17] = mk( 0, 0, 1, 3, 1, 0, 1,  0, 0, 0, 0, 0, 0);
        vecs[18] = mk( 0, 0, 1, 3, 1, 0, 2,  0, 0, 0, 0, 0, 0);
        vecs[19] = mk( 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[20] = mk( 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        // add $7 ; beq $9,$7 (stall caused by rt alone)
        vecs[21] = mk( 0, 0, 3, 3, 1, 7, 1,  0, 0, 0, 0, 0, 0);
        vecs[22] = mk( 9, 7, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        vecs[23] = mk( 9, 7, 0, 0, 0, 0, 0,  0, 0, 2, 0, 0, 0);
        // jal ; jal ; jr $31 (E and M both hold $31 ready: E wins)
        vecs[24] = mk( 0, 0, 3, 3, 1, 31, 0, 0, 0, 0, 0, 3, 0);
        vecs[25] = mk( 0, 0, 3, 3, 1, 31, 0, 0, 0, 0, 0, 0, 0);
        vecs[26] = mk(31, 0, 0, 3, 0, 0, 0,  0, 1, 0, 0, 0, 0);

        // Reset with a would-be hazard on the inputs.
        reset = 1'b1;
        drive(vecs[5]);
        #1;
        chk_idle("reset");
`ifdef STALL_COUNT_EN
        chk("reset_cnt", int'(stall_cnt), 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), int'(stall),    int'(vecs[i].x_stall));
            chk($sformatf("v%0d_fd_rs", i), int'(fwd_D_rs), int'(vecs[i].x_fd_rs));
            chk($sformatf("v%0d_fd_rt", i), int'(fwd_D_rt), int'(vecs[i].x_fd_rt));
            chk($sformatf("v%0d_fe_rs", i), int'(fwd_E_rs), int'(vecs[i].x_fe_rs));
            chk($sformatf("v%0d_fe_rt", i), int'(fwd_E_rt), int'(vecs[i].x_fe_rt));
            chk($sformatf("v%0d_fm_rt", i), int'(fwd_M_rt), int'(vecs[i].x_fm_rt));
            @(posedge clk);
            #1;
        end
`ifdef STALL_COUNT_EN
        chk("stall_cnt_total", int'(stall_cnt), 5);
`endif

        // Reset asserted in the middle of a load-use stall.
        drive(vecs[0]);
        @(posedge clk);
        #1;
        drive(vecs[1]);
        #1;
        chk("rst_pre_stall", int'(stall), 1);
        reset = 1'b1;
        #1;
        chk_idle("rst_async");
`ifdef STALL_COUNT_EN
        chk("rst_async_cnt", int'(stall_cnt), 0);
`endif
        @(posedge clk);
        #1;
        chk_idle("rst_held");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_idle("rst_after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Pipeline hazard unit that sits directly downstream of the D-stage instruction controller.
- Consumes the decoded T_use (rs/rt), write-enable, destination register and T_new of the instruction in D.
- Keeps a shadow record of destination register and remaining T_new for the E, M and W stages.
- Produces the global stall and all forwarding selects for the five-stage MIPS pipeline.

Parameters:
- RAW, 5, register address width.
- TW, 2, width of T_use/T_new fields.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- D_rs  in  RAW  rs field of instruction in D
- D_rt  in  RAW  rt field of instruction in D
- D_tuse_rs  in  TW  T_use of rs (package codes TUSE_D/E/M/NONE)
- D_tuse_rt  in  TW  T_use of rt
- D_wr_en  in  1  instruction in D writes GPR
- D_wr_addr  in  RAW  destination register of D instruction
- D_tnew  in  TW  cycles until result ready, counted at E entry (ALU=1, load=2, jal=0)
- stall  out  1  freeze PC and IF/ID; bubble into D/E
- fwd_D_rs, fwd_D_rt  out  2  D-stage comparator/jr operand source
- fwd_E_rs, fwd_E_rt  out  2  ALU operand source
- fwd_M_rt  out  2  store-data source
- Forward codes (all selects): FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=3.

Behaviour:
- State: per stage S in {E,M,W}: S_addr[RAW], S_tnew[TW]. Also E_rs, E_rt, M_rt.
  - S_addr=0 means no writer; D_wr_en=0 loads addr 0.
- Reset (async): all state registers cleared to 0. Result: stall=0, all fwd=FWD_RF for as long as reset is high and until the first valid writer enters.
- Stall (combinational from D inputs and E/M state), evaluated per operand X in {rs,rt}:
  - stall_X = (tuse_X!=TUSE_NONE) && D_X!=0 && ((E_addr==D_X && E_tnew>tuse_X) || (M_addr==D_X && M_tnew>tuse_X)).
  - stall = stall_rs | stall_rt.
  - W is never checked; W_tnew is 0 by construction.
- Clock edge, no stall:
  - E takes the D fields; E_tnew=D_tnew; E_rs/E_rt latched.
  - M takes E with tnew saturating-decremented (0 stays 0); M_rt latched.
  - W takes M with the same saturating decrement.
- Clock edge, stall:
  - E loads bubble (addr 0, tnew 0, rs/rt 0).
  - M and W advance normally.
  - Repeated stalls behave identically each cycle.
- Forwarding (combinational):
  - Operand A matches stage S when A!=0, S_addr==A and S_tnew==0.
  - fwd_D_*: checks E, then M, then W; first match wins; otherwise FWD_RF.
  - fwd_E_*: checks M, then W; never E.
  - fwd_M_rt: checks W only.
  - Youngest matching writer always wins.
  - A match with tnew!=0 never forwards; stall covers the D-stage case.
- Register $0 is never stalled on and never forwarded, even when a stage addr is 0 with tnew 0.
- Latency: stall and fwd are same-cycle combinational. Pipeline state updates on each rising edge.

Optional Feature:
- STALL_COUNT_EN defined:
  - Adds port stall_cnt out 32.
  - Counter increments on every clock edge where stall=1.
  - Wraps 0xFFFFFFFF→0; cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package/constants header holds:
  - TUSE_D=0, TUSE_E=1, TUSE_M=2, TUSE_NONE=3.
  - TNEW_ALU=1, TNEW_LOAD=2, TNEW_PC8=0.
  - FWD_RF/E/M/W codes.
- One sub-module is natural: hz_stage_reg, holding addr/tnew with a saturating-decrement input path and bubble control. It is instantiated for E, M and W.

Test Plan:
- lw $1 then add $2,$1,$3 (tuse E, tnew 2) → stall high exactly 1 cycle; next cycle fwd_E_rs=FWD_W.
- lw $1 then beq $1,$0 (tuse D) → stall 2 consecutive cycles; third cycle fwd_D_rs=FWD_W, stall=0.
- add $5 then beq $5,$5 → 1 stall; then fwd_D_rs=fwd_D_rt=FWD_M.
- jal (dest 31, tnew 0) then jr $31 → no stall; fwd_D_rs=FWD_E.
- lw $4 then sw $4,0($6) (tuse_rt M) → no stall; two cycles later fwd_M_rt=FWD_W.
- Writers to $0 ahead of beq $0,$0 → never stall, all fwd=FWD_RF.
- Assert reset during an active lw stall → stall drops immediately and all fwd=FWD_RF; with STALL_COUNT_EN, stall_cnt reads 0.
